// File: rtl/bcd_display_formatter_pkg.sv
// Shared definitions for the display formatter and the seven-segment driver:
// digit codes for the non-numeric glyphs, converter geometry and FSM encodings.
package bcd_display_formatter_pkg;

  // Digit codes understood by the seven-segment driver
  localparam logic [3:0] CODE_C_DEF     = 4'd10;
  localparam logic [3:0] CODE_DASH_DEF  = 4'd11;
  localparam logic [3:0] CODE_BLANK_DEF = 4'd15;

  // Converter geometry: 14-bit magnitude covers 0..9999, four BCD nibbles out
  localparam int MAG_W = 14;
  localparam int BCD_W = 16;
  localparam logic [3:0] SHIFT_LAST = 4'(MAG_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREP   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FORMAT = 2'd3
  } fmt_state_e;

endpackage

// File: rtl/bin2bcd_iter.sv
// Sequential double-dabble: converts a 14-bit unsigned magnitude into four
// BCD nibbles, one shift per clock. start loads the operand and clears the
// accumulator; done is high during the cycle whose edge performs the last shift,
// so bcd is valid from the following cycle onward.
module bin2bcd_iter
  import bcd_display_formatter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [MAG_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic             run_q;

  // Add 3 to every nibble that is 5 or more so the following shift carries correctly
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Shift-phase control: running flag and iteration counter 0..13
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      if (cnt_q == SHIFT_LAST) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // Shift datapath: operand load on start, adjust-and-shift while running
  always_ff @(posedge clk) begin
    if (start) begin
      bin_sh <= bin;
      bcd_q  <= '0;
    end else if (run_q) begin
      {bcd_q, bin_sh} <= {dabble_adj(bcd_q), bin_sh} << 1;
    end
  end

  assign bcd  = bcd_q;
  assign done = run_q && (cnt_q == SHIFT_LAST);

endmodule

// File: rtl/bcd_display_formatter.sv
// Turns a signed binary value into the {BCD3,BCD2,BCD1,BCD0} word for the
// four-digit seven-segment driver: sign/range preparation, iterative BCD
// conversion, leading-zero blanking, minus placement and optional 'C' suffix.
module bcd_display_formatter
  import bcd_display_formatter_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter logic [3:0] CODE_C     = CODE_C_DEF,
  parameter logic [3:0] CODE_DASH  = CODE_DASH_DEF,
  parameter logic [3:0] CODE_BLANK = CODE_BLANK_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic signed [WIDTH-1:0] value_i,
  input  logic                    unit_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             nums_o
);

  localparam logic signed [WIDTH-1:0] LO_FOUR  = WIDTH'(-999);
  localparam logic signed [WIDTH-1:0] HI_FOUR  = WIDTH'(9999);
  localparam logic signed [WIDTH-1:0] LO_THREE = WIDTH'(-99);
  localparam logic signed [WIDTH-1:0] HI_THREE = WIDTH'(999);

  fmt_state_e state_q, state_d;

  logic signed [WIDTH-1:0] value_p0;
  logic                    unit_p0;
  logic                    neg_c, oor_c;
  logic [WIDTH-1:0]        abs_c;
  logic [MAG_W-1:0]        mag_c;
  logic                    neg_p1, oor_p1;
  logic                    cvt_start, cvt_done;
  logic [BCD_W-1:0]        cvt_bcd;
  logic                    accept;

  // Blank leading zeros, drop a dash left of the most significant digit, then
  // pick the four-digit or three-digit-plus-'C' layout. For the 'C' layout the
  // magnitude is at most 999, so the top nibble is always a blank that gets dropped.
  function automatic logic [15:0] format_nums(input logic [BCD_W-1:0] bcd,
                                              input logic neg,
                                              input logic unit,
                                              input logic oor);
    logic [3:0] d [4];
    logic [3:0] r [4];
    logic       lead;
    for (int i = 0; i < 4; i++) d[i] = bcd[i*4 +: 4];
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (d[i] == 4'd0)) begin
        r[i] = CODE_BLANK;
      end else begin
        lead = 1'b0;
        r[i] = d[i];
      end
    end
    r[0] = d[0];
    if (neg) begin
      if (d[3] != 4'd0)      r[3] = r[3];
      else if (d[2] != 4'd0) r[3] = CODE_DASH;
      else if (d[1] != 4'd0) r[2] = CODE_DASH;
      else                   r[1] = CODE_DASH;
    end
    if (oor)       return {4{CODE_DASH}};
    else if (unit) return {r[2], r[1], r[0], CODE_C};
    else           return {r[3], r[2], r[1], r[0]};
  endfunction

  assign accept    = (state_q == ST_IDLE) && load_i;
  assign cvt_start = (state_q == ST_PREP);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: the FORMAT cycle always returns to IDLE, so a load there is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load_i) state_d = ST_PREP;
      ST_PREP:   state_d = ST_SHIFT;
      ST_SHIFT:  if (cvt_done) state_d = ST_FORMAT;
      ST_FORMAT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---- stage p0: request capture ----
  // Operands are frozen at load so later changes on the inputs are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      value_p0 <= value_i;
      unit_p0  <= unit_i;
    end
  end

  // Sign, magnitude and range; a magnitude that overflows 14 bits (including the
  // most negative value, whose negation wraps) is out of range as well
  always_comb begin
    neg_c = value_p0[WIDTH-1];
    abs_c = neg_c ? WIDTH'(-value_p0) : WIDTH'(value_p0);
    mag_c = abs_c[MAG_W-1:0];
    if (unit_p0) oor_c = (value_p0 < LO_THREE) || (value_p0 > HI_THREE);
    else         oor_c = (value_p0 < LO_FOUR)  || (value_p0 > HI_FOUR);
    oor_c = oor_c || (|abs_c[WIDTH-1:MAG_W]);
  end

  // ---- stage p1: PREP results held through the conversion ----
  // Sign and range flags registered on the PREP edge
  always_ff @(posedge clk) begin
    if (cvt_start) begin
      neg_p1 <= neg_c;
      oor_p1 <= oor_c;
    end
  end

  bin2bcd_iter u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .bin   (mag_c),
    .bcd   (cvt_bcd),
    .done  (cvt_done)
  );

  // ---- stage p2: formatted output and handshake ----
  // nums_o, done_o and busy_o all change together on the FORMAT edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nums_o <= 16'hFFFF;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) busy_o <= 1'b1;
      if (state_q == ST_FORMAT) begin
        nums_o <= format_nums(cvt_bcd, neg_p1, unit_p0, oor_p1);
        done_o <= 1'b1;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter: latency/handshake, formatting cases,
// ignored loads, reset abort and a strided sweep against a reference model.
module tb_bcd_display_formatter;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_i;
  logic signed [15:0] value_i;
  logic               unit_i;
  logic               busy_o;
  logic               done_o;
  logic [15:0]        nums_o;

  int checks = 0;
  int fails  = 0;

  bcd_display_formatter dut (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_i),
    .value_i (value_i),
    .unit_i  (unit_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .nums_o  (nums_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive load_i for exactly one edge (edge N); returns 1 time unit after edge N
  task automatic pulse_load(input int v, input bit u);
    value_i = 16'(v);
    unit_i  = u;
    load_i  = 1'b1;
    step();
    load_i  = 1'b0;
  endtask

  // Independent reference: decimal digits by division, then blanking and sign
  function automatic logic [15:0] ref_fmt(input int v, input bit u);
    int         m, n, first;
    bit         found;
    logic [3:0] dig [4];
    logic [3:0] p [4];
    if (!u && (v < -999 || v > 9999)) return 16'hBBBB;
    if (u && (v < -99 || v > 999))    return 16'hBBBB;
    m = (v < 0) ? -v : v;
    dig[0] = 4'(m % 10);
    dig[1] = 4'((m / 10) % 10);
    dig[2] = 4'((m / 100) % 10);
    dig[3] = 4'((m / 1000) % 10);
    n = u ? 3 : 4;
    for (int i = 0; i < 4; i++) p[i] = 4'hF;
    for (int i = 0; i < n; i++) p[i] = dig[n-1-i];
    first = n - 1;
    found = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      if (!found && p[i] != 4'd0) begin
        first = i;
        found = 1'b1;
      end
    end
    for (int i = 0; i < first; i++) p[i] = 4'hF;
    if (v < 0) p[first-1] = 4'hB;
    if (u) return {p[0], p[1], p[2], 4'hA};
    return {p[0], p[1], p[2], p[3]};
  endfunction

  // Full conversion; optionally checks the busy/done timing as well
  task automatic convert(input int v, input bit u, input logic [15:0] exp,
                         input string tag, input bit timing);
    int busy_cnt, early_done;
    pulse_load(v, u);
    busy_cnt   = int'(busy_o);
    early_done = int'(done_o);
    for (int i = 0; i < 15; i++) begin
      step();
      busy_cnt   += int'(busy_o);
      early_done += int'(done_o);
    end
    step();
    check({tag, "_nums"}, nums_o, exp);
    if (timing) begin
      check({tag, "_done"}, 16'(done_o), 16'd1);
      check({tag, "_busy_low"}, 16'(busy_o), 16'd0);
      check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd16);
      check({tag, "_no_early_done"}, 16'(early_done), 16'd0);
      step();
      check({tag, "_done_pulse"}, 16'(done_o), 16'd0);
    end
  endtask

  initial begin
    int dones;
    rst     = 1'b1;
    load_i  = 1'b0;
    value_i = '0;
    unit_i  = 1'b0;
    step();
    step();
    check("reset_nums", nums_o, 16'hFFFF);
    check("reset_busy", 16'(busy_o), 16'd0);
    check("reset_done", 16'(done_o), 16'd0);
    rst = 1'b0;
    step();

    // Basic conversion with latency and handshake timing
    convert(1234, 1'b0, 16'h1234, "v1234", 1'b1);

    // Blanking and sign placement
    convert(0,    1'b0, 16'hFFF0, "v0",    1'b1);
    convert(-7,   1'b0, 16'hFFB7, "vm7",   1'b0);
    convert(-999, 1'b0, 16'hB999, "vm999", 1'b0);
    convert(50,   1'b0, 16'hFF50, "v50",   1'b0);
    convert(-40,  1'b0, 16'hFB40, "vm40",  1'b0);

    // 'C' suffix mode and out-of-range
    convert(25,     1'b1, 16'hF25A, "c25",    1'b0);
    convert(-42,    1'b1, 16'hB42A, "cm42",   1'b0);
    convert(1000,   1'b1, 16'hBBBB, "c1000",  1'b0);
    convert(-100,   1'b1, 16'hBBBB, "cm100",  1'b0);
    convert(999,    1'b1, 16'h999A, "c999",   1'b0);
    convert(0,      1'b1, 16'hFF0A, "c0",     1'b0);
    convert(10000,  1'b0, 16'hBBBB, "v10000", 1'b0);
    convert(-1000,  1'b0, 16'hBBBB, "vm1000", 1'b0);
    convert(-32768, 1'b0, 16'hBBBB, "vmin",   1'b0);

    // Loads during busy and on the FORMAT edge are dropped; reload after done works
    dones = 0;
    pulse_load(321, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5 || i == 16) begin
        value_i = (i == 5) ? 16'sd7777 : 16'sd5555;
        unit_i  = 1'b1;
        load_i  = 1'b1;
      end
      step();
      load_i = 1'b0;
      dones += int'(done_o);
    end
    check("ign_nums", nums_o, 16'hF321);
    check("ign_done_now", 16'(done_o), 16'd1);
    check("ign_format_load", 16'(busy_o), 16'd0);
    pulse_load(4321, 1'b0);
    check("reload_busy", 16'(busy_o), 16'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      dones += int'(done_o);
    end
    check("reload_nums", nums_o, 16'h4321);
    check("ign_done_count", 16'(dones), 16'd2);
    step();

    // Reset in the middle of the shift phase aborts without a done pulse
    pulse_load(1234, 1'b0);
    for (int i = 0; i < 7; i++) step();
    #2 rst = 1'b1;
    #1;
    check("abort_nums", nums_o, 16'hFFFF);
    check("abort_busy", 16'(busy_o), 16'd0);
    check("abort_done", 16'(done_o), 16'd0);
    step();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      dones += int'(done_o);
    end
    check("abort_no_done", 16'(dones), 16'd0);
    check("abort_nums_hold", nums_o, 16'hFFFF);
    convert(9999, 1'b0, 16'h9999, "after_abort", 1'b1);

    // Strided sweep of the four-digit range plus its edges
    for (int v = -999; v <= 9999; v += 11) begin
      convert(v, 1'b0, ref_fmt(v, 1'b0), $sformatf("sweep_%0d", v), 1'b0);
    end
    convert(9999, 1'b0, ref_fmt(9999, 1'b0), "sweep_9999", 1'b0);
    convert(-1,   1'b0, ref_fmt(-1, 1'b0),   "sweep_m1",   1'b0);
    convert(-10,  1'b0, ref_fmt(-10, 1'b0),  "sweep_m10",  1'b0);
    convert(100,  1'b0, ref_fmt(100, 1'b0),  "sweep_100",  1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
